// File: rtl/cbu_pkg.sv
// Shared constants for the CBU up-counter family.
package cbu_pkg;

    localparam logic MODE_FULL = 1'b0;
    localparam logic MODE_MOD  = 1'b1;

    localparam int unsigned CBU_WIDTH = 16;

endpackage

// File: rtl/cbu_term_cmp.sv
// Terminal-value select and equality compare for the CBU up counters.
module cbu_term_cmp
    import cbu_pkg::*;
#(
    parameter int unsigned WIDTH = CBU_WIDTH
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic             modsel_i,
    input  logic [WIDTH-1:0] modv_i,
    output logic [WIDTH-1:0] term_o,
    output logic             eq_o
);

    always_comb begin
        term_o = (modsel_i == MODE_MOD) ? modv_i : {WIDTH{1'b1}};
        eq_o   = (q_i == term_o);
    end

endmodule

// File: rtl/cbua16_mod.sv
// 16-bit cascadable up counter with load, preset, programmable modulus and one-shot mode.
module cbua16_mod
    import cbu_pkg::*;
#(
    parameter int unsigned WIDTH   = CBU_WIDTH,
    parameter bit          ONESHOT = 1'b0
) (
    input  logic             CLK,
    input  logic             CD,
    input  logic             SD,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             CAI,
    input  logic             MODSEL,
    input  logic [WIDTH-1:0] MODV,
    output logic [WIDTH-1:0] Q,
    output logic             CAO,
    output logic             TCP,
    output logic             DONE
);

    logic [WIDTH-1:0] q_d, q_q;
    logic             tcp_d, tcp_q;
    logic             done_d, done_q;
    logic [WIDTH-1:0] term;
    logic             at_term;
    logic             adv;

    cbu_term_cmp #(
        .WIDTH (WIDTH)
    ) u_term_cmp (
        .q_i      (q_q),
        .modsel_i (MODSEL),
        .modv_i   (MODV),
        .term_o   (term),
        .eq_o     (at_term)
    );

    assign adv = CAI & EN & ~done_q;
    // Carry chain stays purely combinational so cascaded stages advance on the same edge.
    assign CAO = adv & at_term;

    always_comb begin
        q_d    = q_q;
        tcp_d  = 1'b0;
        done_d = done_q;
        if (SD) begin
            q_d    = {WIDTH{1'b1}};
            done_d = 1'b0;
        end else if (LD) begin
            q_d    = D;
            done_d = 1'b0;
        end else if (adv) begin
            if (at_term) begin
                q_d    = '0;
                tcp_d  = 1'b1;
                done_d = ONESHOT;
            end else begin
                // Above an out-of-range MODV this wraps through 0 without a terminal advance.
                q_d = q_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CD) begin
            q_q    <= '0;
            tcp_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            tcp_q  <= tcp_d;
            done_q <= done_d;
        end
    end

    assign Q    = q_q;
    assign TCP  = tcp_q;
    assign DONE = done_q;

    logic unused_term;
    assign unused_term = ^term;

endmodule

// File: tb/tb_cbua16_mod.sv
// Directed self-checking bench for cbua16_mod: wrap, modulo, one-shot, priority, cascade.
module tb_cbua16_mod;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Main free-running instance
    logic        cd = 0, sd = 0, ld = 0, en = 0, cai = 0, modsel = 0;
    logic [15:0] d = '0, modv = '0, q;
    logic        cao, tcp, done;

    // One-shot instance
    logic        o_cd = 0, o_ld = 0, o_en = 0;
    logic [15:0] o_q;
    logic        o_cao, o_tcp, o_done;

    // Cascaded pair
    logic        c_cd = 0, c_ld = 0, c_en = 0;
    logic [31:0] c_d = '0;
    logic [15:0] c_qlo, c_qhi;
    logic        c_cao_lo, c_cao_hi, c_tcp_lo, c_tcp_hi, c_done_lo, c_done_hi;

    int tests_run = 0;
    int tests_failed = 0;

    cbua16_mod #(.WIDTH(16), .ONESHOT(1'b0)) dut (
        .CLK(clk), .CD(cd), .SD(sd), .LD(ld), .D(d), .EN(en), .CAI(cai),
        .MODSEL(modsel), .MODV(modv), .Q(q), .CAO(cao), .TCP(tcp), .DONE(done)
    );

    cbua16_mod #(.WIDTH(16), .ONESHOT(1'b1)) dut_os (
        .CLK(clk), .CD(o_cd), .SD(1'b0), .LD(o_ld), .D(16'h0000), .EN(o_en), .CAI(1'b1),
        .MODSEL(1'b1), .MODV(16'd2), .Q(o_q), .CAO(o_cao), .TCP(o_tcp), .DONE(o_done)
    );

    cbua16_mod #(.WIDTH(16), .ONESHOT(1'b0)) dut_lo (
        .CLK(clk), .CD(c_cd), .SD(1'b0), .LD(c_ld), .D(c_d[15:0]), .EN(c_en), .CAI(1'b1),
        .MODSEL(1'b0), .MODV(16'h0000), .Q(c_qlo), .CAO(c_cao_lo), .TCP(c_tcp_lo),
        .DONE(c_done_lo)
    );

    cbua16_mod #(.WIDTH(16), .ONESHOT(1'b0)) dut_hi (
        .CLK(clk), .CD(c_cd), .SD(1'b0), .LD(c_ld), .D(c_d[31:16]), .EN(c_en), .CAI(c_cao_lo),
        .MODSEL(1'b0), .MODV(16'h0000), .Q(c_qhi), .CAO(c_cao_hi), .TCP(c_tcp_hi),
        .DONE(c_done_hi)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle past it before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp_q;
        int          tcp_seen;

        // Free-running wrap
        cd = 1; tick();
        check_eq("rst_q", q, 16'h0000);
        check_eq("rst_tcp", tcp, 1'b0);
        check_eq("rst_done", done, 1'b0);
        cd = 0; ld = 1; d = 16'hFFFD; tick();
        check_eq("ld_q", q, 16'hFFFD);
        ld = 0; en = 1; cai = 1; #1;
        check_eq("wrap_cao_fffd", cao, 1'b0);
        tick(); check_eq("wrap_q1", q, 16'hFFFE); check_eq("wrap_cao1", cao, 1'b0);
        tick(); check_eq("wrap_q2", q, 16'hFFFF); check_eq("wrap_cao2", cao, 1'b1);
        check_eq("wrap_tcp2", tcp, 1'b0);
        tick(); check_eq("wrap_q3", q, 16'h0000); check_eq("wrap_tcp3", tcp, 1'b1);
        check_eq("wrap_cao3", cao, 1'b0);
        tick(); check_eq("wrap_q4", q, 16'h0001); check_eq("wrap_tcp4", tcp, 1'b0);
        check_eq("free_done", done, 1'b0);

        // Modulo 4 count; CD wins over a live enable
        modsel = 1; modv = 16'd4; cd = 1; tick();
        check_eq("mod_rst_q", q, 16'h0000);
        check_eq("mod_rst_cao", cao, 1'b0);
        cd = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp_q = 16'((i + 1) % 5);
            check_eq($sformatf("mod_q%0d", i), q, exp_q);
            check_eq($sformatf("mod_tcp%0d", i), tcp, (exp_q == 0));
        end

        // MODV=0: every advance is terminal
        modv = 16'd0; cd = 1; tick(); cd = 0; #1;
        check_eq("m0_cao_rst", cao, 1'b1);
        tick(); check_eq("m0_q1", q, 16'h0000); check_eq("m0_tcp1", tcp, 1'b1);
        tick(); check_eq("m0_tcp2", tcp, 1'b1);
        en = 0; #1; check_eq("m0_cao_en0", cao, 1'b0);
        tick(); check_eq("m0_tcp_en0", tcp, 1'b0);

        // Out-of-range modulus wraps through 0 without a terminal advance
        modv = 16'd3; ld = 1; d = 16'hFFFE; tick();
        ld = 0; en = 1;
        tick(); check_eq("oor_q1", q, 16'hFFFF); check_eq("oor_cao_ffff", cao, 1'b0);
        tick(); check_eq("oor_q2", q, 16'h0000); check_eq("oor_tcp2", tcp, 1'b0);
        tick(); check_eq("oor_q3", q, 16'h0001);
        tick(); check_eq("oor_q4", q, 16'h0002);

        // Priority
        en = 0; modsel = 0; cd = 1; sd = 1; ld = 1; d = 16'h1234; tick();
        check_eq("pri_cd", q, 16'h0000);
        cd = 0; tick();
        check_eq("pri_sd", q, 16'hFFFF);
        sd = 0; en = 1; #1;
        check_eq("pri_cao_ld", cao, 1'b1);
        tick();
        check_eq("pri_ld_q", q, 16'h1234);
        check_eq("pri_ld_tcp", tcp, 1'b0);
        ld = 0; en = 0;

        // One-shot, MODV=2
        o_cd = 1; tick(); o_cd = 0; o_en = 1;
        tick(); check_eq("os_q1", o_q, 16'd1); check_eq("os_done1", o_done, 1'b0);
        tick(); check_eq("os_q2", o_q, 16'd2); check_eq("os_cao2", o_cao, 1'b1);
        tick(); check_eq("os_q3", o_q, 16'd0); check_eq("os_done3", o_done, 1'b1);
        check_eq("os_tcp3", o_tcp, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("os_hold_q%0d", i), o_q, 16'd0);
            check_eq($sformatf("os_hold_done%0d", i), o_done, 1'b1);
            check_eq($sformatf("os_hold_cao%0d", i), o_cao, 1'b0);
            check_eq($sformatf("os_hold_tcp%0d", i), o_tcp, 1'b0);
        end
        o_ld = 1; tick(); check_eq("os_ld_done", o_done, 1'b0);
        o_ld = 0; tick(); check_eq("os_resume_q", o_q, 16'd1);
        o_en = 0;

        // Cascade: 32-bit from two stages
        c_cd = 1; tick(); c_cd = 0;
        c_ld = 1; c_d = 32'h0000_FFFF; tick();
        c_ld = 0; c_en = 1; #1;
        check_eq("cas_cao_lo", c_cao_lo, 1'b1);
        tcp_seen = 0;
        tick(); c_en = 0;
        check_eq("cas_q", {c_qhi, c_qlo}, 32'h0001_0000);
        tcp_seen += int'(c_tcp_lo);
        tick();
        tcp_seen += int'(c_tcp_lo);
        check_eq("cas_tcp_lo_count", tcp_seen, 1);
        check_eq("cas_tcp_hi", c_tcp_hi, 1'b0);
        check_eq("cas_done", {c_done_hi, c_done_lo, c_cao_hi}, 3'b000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cbua16_mod.md
# cbua16_mod

16-bit synchronous up counter with carry-in/carry-out cascade, parallel load, synchronous preset, programmable modulus and one-shot mode. It is the count-up counterpart to the CBDA-family down counters: its CAO/CAI chain uses the same cascade contract, so stages can be chained for wider counters. It sits in the macro behavioural library and serves as a period/prescaler timer, with a registered terminal-count pulse for downstream logic.

## Interface

Parameters:
- WIDTH, 16: counter width in bits.
- ONESHOT, 0: 0 = free-running; 1 = counter stops after one terminal advance.

Ports:
- CLK, in, 1: clock; all state changes on its rising edge.
- CD, in, 1: reset/clear, synchronous, active-high. Q=0, DONE=0, TCP=0.
- SD, in, 1: synchronous preset. Q = all ones. Clears DONE.
- LD, in, 1: synchronous parallel load. Q = D. Clears DONE.
- D, in, WIDTH: load data.
- EN, in, 1: count enable.
- CAI, in, 1: cascade carry in. Tie high on the least significant stage.
- MODSEL, in, 1: 0 = terminal value is all ones; 1 = terminal value is MODV.
- MODV, in, WIDTH: modulus terminal value, used when MODSEL=1.
- Q, out, WIDTH: count value (registered).
- CAO, out, 1: cascade carry out (combinational).
- TCP, out, 1: registered terminal-count pulse, one cycle wide.
- DONE, out, 1: one-shot completed flag (registered; always 0 when ONESHOT=0).

## Operation

- TERM = MODSEL ? MODV : all ones.
- adv = CAI & EN & ~DONE.
- Priority at each CLK edge: CD > SD > LD > adv > hold.
- Count when adv is high:
  - If Q == TERM, then Q becomes 0. This is a terminal advance.
  - Otherwise Q becomes Q+1, modulo 2^WIDTH.
- Modulo mode with Q > MODV (after a load or a MODV change):
  - Count continues upward and wraps from all ones to 0.
  - This wrap is not a terminal advance: no CAO, no TCP.
  - Normal modulo counting resumes from 0.
- CAO = adv & (Q == TERM). Purely combinational, with no dependence on LD, SD or CD.
- TCP = 1 in the cycle after a terminal advance. Otherwise 0.
- ONESHOT=1:
  - A terminal advance sets DONE (Q wraps to 0).
  - While DONE=1, adv is forced low: Q holds and CAO stays 0.
  - DONE is cleared by CD, SD or LD.
- MODV = 0 in modulo mode: every adv is a terminal advance. Q stays 0 and TCP pulses on each advancing edge.
- EN=0 or CAI=0: Q holds, CAO=0, TCP=0 on the next cycle.

## Timing

- Reset values after a CD edge: Q=0, TCP=0, DONE=0. CAO then equals CAI & EN & (TERM==0).
- Q latency: the update is visible one cycle after the qualifying edge.
- CAO latency: zero; it is valid in the same cycle that Q==TERM and adv hold.
- TCP latency: one cycle after CAO was high at the edge. Back-to-back terminal advances give a TCP high on consecutive cycles.
- LD and adv in the same cycle: the load wins, no terminal advance, TCP=0 next cycle.
- SD and LD in the same cycle: the preset wins.
- CD during any activity: the clear wins. A pending TCP is suppressed (TCP=0 on the next cycle).
- Cascading:
  - Stage n's CAO drives stage n+1's CAI. All stages share CLK, EN, CD.
  - The combinational CAO path must settle in one CLK period.

## Structure

- Shared package cbu_pkg holds:
  - MODE_FULL=1'b0 and MODE_MOD=1'b1 for MODSEL.
  - Default width constant CBU_WIDTH=16.
- One sub-module, cbu_term_cmp:
  - Selects TERM and produces the equality flag.
  - Reused by future up counters.
- Top-level registers: Q, TCP, DONE.

## Test plan

- Free-running wrap: CD, then LD D=16'hFFFD, then EN=CAI=1 for 4 cycles. Required: Q = FFFE, FFFF, 0000, 0001. CAO=1 only while Q=FFFF. TCP=1 in the cycle Q=0000.
- Modulo count: MODSEL=1, MODV=4, CD, count for 12 cycles. Required: Q cycles 1,2,3,4,0,... and TCP pulses every 5th cycle.
- One-shot: ONESHOT=1, MODV=2, count for 6 cycles. Required: Q = 1,2,0, then holds at 0. DONE=1 from the cycle Q=0 onward and CAO stays 0. Then LD D=0: DONE=0 and counting resumes.
- Priority: assert CD, SD and LD together with D=16'h1234. Required: Q=0. Then SD+LD: Q=FFFF. Then LD with Q==TERM: Q=1234 and TCP=0.
- Cascade: two instances chained give a 32-bit counter. LD 32'h0000_FFFF then one count. Required: {hi,lo}=32'h0001_0000, with exactly one TCP on the low stage.
- Out-of-range modulus: MODSEL=1, MODV=3, LD D=16'hFFFE, count for 4 cycles. Required: Q = FFFF, 0000, 0001, 0002, with no CAO or TCP during the FFFF to 0000 wrap.
